// File: rtl/ram_bank_controller.sv
// Byte-banked RAM controller: byte/half/word big-endian access over LANES banks with an Enable/MOC handshake.
// Optional build macro RAM_ALIGN_CHECK_EN rejects misaligned half/word requests and raises AlignErr.

module ram_bank_lane #(
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  // Deliberately not reset; contents survive Reset
  logic [7:0] mem [2**ROW_W];

  always_ff @(posedge clk)
    if (we) mem[row] <= wdata;

  assign rdata = mem[row];
endmodule

module ram_bank_controller #(
  parameter int ADDR_W      = 9,
  parameter int LANES       = 4,
  parameter int WAIT_STATES = 1,
  localparam int DATA_W     = 8 * LANES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [1:0]        Mode,
  input  logic              Signed,
  output logic [DATA_W-1:0] DataOut,
  output logic              MOC,
  output logic              Busy,
  output logic              AlignErr
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        mode;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } req_t;

  state_t state, state_nxt;
  req_t   req;
  logic [3:0] cnt;
  logic       last, misalign, commit;
  logic [LANES-1:0]       sel;
  logic [LANES-1:0][7:0]  lane_wd, lane_rd;
  logic [7:0]             rd_b;
  logic [15:0]            rd_h;
  logic [DATA_W-1:0]      rd_val;

  assign last   = (state == ACCESS) && (cnt == 4'(WAIT_STATES));
  assign Busy   = (state != IDLE);
  assign MOC    = (state == DONE);

`ifdef RAM_ALIGN_CHECK_EN
  assign misalign = (req.mode == 2'd1 && req.addr[0]) ||
                    (req.mode == 2'd2 && req.addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Writes land only on the edge leaving ACCESS, so a reset before then leaves memory untouched
  assign commit = last && !req.rw && !misalign;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable)  state_nxt = ACCESS;
      ACCESS:  if (last)    state_nxt = DONE;
      DONE:    if (!Enable) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Bank L holds byte addresses with A%4 == L; lane 0 is the MSB of a word (big-endian)
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sel[l] = (req.mode == 2'd2) ||
                    (req.mode == 2'd1 && req.addr[1] == 1'(l / 2)) ||
                    (req.mode == 2'd0 && req.addr[1:0] == 2'(l));
    assign lane_wd[l] = (req.mode == 2'd2)           ? req.din[8*(LANES-1-l) +: 8] :
                        (req.mode == 2'd1 && l%2 == 0) ? req.din[15:8] : req.din[7:0];

    ram_bank_lane #(.ROW_W(ADDR_W-2)) u_lane (
      .clk   (Clk),
      .we    (commit && sel[l]),
      .row   (req.addr[ADDR_W-1:2]),
      .wdata (lane_wd[l]),
      .rdata (lane_rd[l])
    );
  end

  assign rd_b = lane_rd[req.addr[1:0]];
  assign rd_h = {lane_rd[{req.addr[1], 1'b0}], lane_rd[{req.addr[1], 1'b1}]};

  always_comb begin
    rd_val = '0;
    case (req.mode)
      2'd0: rd_val = {{(DATA_W-8){req.sgn & rd_b[7]}}, rd_b};
      2'd1: rd_val = {{(DATA_W-16){req.sgn & rd_h[15]}}, rd_h};
      2'd2: rd_val = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
      default: rd_val = '0;
    endcase
    if (misalign) rd_val = '0;
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      req      <= '0;
      cnt      <= '0;
      DataOut  <= '0;
      AlignErr <= 1'b0;
    end else begin
      if (state == IDLE && Enable) begin
        req <= '{rw: ReadWrite, mode: Mode, sgn: Signed, addr: Address, din: DataIn};
        cnt <= '0;
      end else if (state == ACCESS && !last) begin
        cnt <= cnt + 4'd1;
      end
      if (last) begin
        DataOut  <= req.rw ? rd_val : '0;
        AlignErr <= misalign;
      end
    end
endmodule

// File: tb/tb_ram_bank_controller.sv
// Directed bench for ram_bank_controller (WAIT_STATES=2): vector table plus reset/handshake sequences.
module tb_ram_bank_controller;
  localparam int WS = 2;
`ifdef RAM_ALIGN_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic        Clk = 0, Reset = 1, Enable = 0, ReadWrite = 0, Signed = 0;
  logic [8:0]  Address = '0;
  logic [31:0] DataIn = '0;
  logic [1:0]  Mode = '0;
  logic [31:0] DataOut;
  logic        MOC, Busy, AlignErr;

  int tests = 0, fails = 0;

  ram_bank_controller #(.ADDR_W(9), .LANES(4), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ReadWrite(ReadWrite),
    .Address(Address), .DataIn(DataIn), .Mode(Mode), .Signed(Signed),
    .DataOut(DataOut), .MOC(MOC), .Busy(Busy), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic [8:0]  a;
    logic [1:0]  m;
    logic        s;
    logic [31:0] d;
    logic [31:0] exp;
    logic        ae;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full 4-phase access; returns data, AlignErr and edges from request to MOC
  task automatic access(input logic rw, input logic [8:0] a, input logic [1:0] m, input logic s,
                        input logic [31:0] d, output logic [31:0] dout, output logic ae,
                        output int lat);
    ReadWrite = rw; Address = a; Mode = m; Signed = s; DataIn = d; Enable = 1;
    lat = 0;
    do begin
      @(posedge Clk); #1; lat++;
    end while (!MOC && lat < 50);
    chk("moc_seen", {31'b0, MOC}, 32'd1);
    dout = DataOut; ae = AlignErr;
    Enable = 0;
    @(posedge Clk); #1;
    chk("handshake_drop", {30'b0, MOC, Busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] dout;
    logic        ae;
    int          lat;

    vt[0]  = '{1'b0, 9'h010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 9'h010, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 9'h011, 2'd0, 1'b0, 32'h0,        32'h000000AD, 1'b0};
    vt[3]  = '{1'b1, 9'h010, 2'd0, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0};
    vt[4]  = '{1'b1, 9'h012, 2'd1, 1'b1, 32'h0,        32'hFFFFBEEF, 1'b0};
    vt[5]  = '{1'b1, 9'h010, 2'd1, 1'b0, 32'h0,        32'h0000DEAD, 1'b0};
    vt[6]  = '{1'b1, 9'h013, 2'd0, 1'b1, 32'h0,        32'hFFFFFFEF, 1'b0};
    vt[7]  = '{1'b0, 9'h012, 2'd1, 1'b0, 32'hFFFF1234, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 9'h010, 2'd0, 1'b0, 32'hFFFFFF55, 32'h0,        1'b0};
    vt[9]  = '{1'b1, 9'h010, 2'd2, 1'b0, 32'h0,        32'h55AD1234, 1'b0};
    vt[10] = '{1'b1, 9'h013, 2'd2, 1'b0, 32'h0,        ACHK ? 32'h0 : 32'h55AD1234, ACHK};
    vt[11] = '{1'b1, 9'h011, 2'd1, 1'b0, 32'h0,        ACHK ? 32'h0 : 32'h000055AD, ACHK};
    vt[12] = '{1'b0, 9'h1FC, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[13] = '{1'b1, 9'h1FC, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[14] = '{1'b1, 9'h1FC, 2'd3, 1'b0, 32'h0,        32'h0,        1'b0};
    vt[15] = '{1'b0, 9'h1FC, 2'd3, 1'b0, 32'h12345678, 32'h0,        1'b0};
    vt[16] = '{1'b1, 9'h1FC, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[17] = '{1'b1, 9'h1FE, 2'd1, 1'b1, 32'h0,        32'hFFFFF00D, 1'b0};

    // Reset state
    #12;
    chk("reset_outputs", {DataOut[27:0], MOC, Busy, AlignErr, 1'b0}, 32'd0);
    chk("reset_dataout", DataOut, 32'd0);
    Reset = 0;
    @(posedge Clk); #1;

    // Reset during an uncommitted word write leaves memory and outputs clean
    access(1'b0, 9'h020, 2'd2, 1'b0, 32'hA5A55A5A, dout, ae, lat);
    access(1'b1, 9'h020, 2'd2, 1'b0, 32'h0, dout, ae, lat);
    chk("prior_word", dout, 32'hA5A55A5A);
    ReadWrite = 0; Address = 9'h020; Mode = 2'd2; DataIn = 32'h11223344; Enable = 1;
    @(posedge Clk); #1;
    chk("busy_after_accept", {31'b0, Busy}, 32'd1);
    @(posedge Clk); #1;
    Reset = 1; #1;
    chk("midreset_dataout", DataOut, 32'd0);
    chk("midreset_ctl", {29'b0, MOC, Busy, AlignErr}, 32'd0);
    #2; Reset = 0; Enable = 0;
    @(posedge Clk); #1;
    access(1'b1, 9'h020, 2'd2, 1'b0, 32'h0, dout, ae, lat);
    chk("after_reset_word", dout, 32'hA5A55A5A);

    // Vector table
    foreach (vt[i]) begin
      access(vt[i].rw, vt[i].a, vt[i].m, vt[i].s, vt[i].d, dout, ae, lat);
      if (vt[i].rw) chk($sformatf("vec%0d_data", i), dout, vt[i].exp);
      chk($sformatf("vec%0d_alignerr", i), {31'b0, ae}, {31'b0, vt[i].ae});
    end

    // MOC latency and hold while Enable stays high
    ReadWrite = 1; Address = 9'h010; Mode = 2'd2; Signed = 0; Enable = 1;
    lat = 0;
    do begin
      @(posedge Clk); #1; lat++;
      if (lat == 1) chk("busy_no_moc", {30'b0, Busy, MOC}, 32'd2);
    end while (!MOC && lat < 50);
    chk("moc_latency", lat, WS + 2);
    repeat (2) @(posedge Clk);
    #1;
    chk("moc_hold", {30'b0, MOC, Busy}, 32'd3);
    chk("hold_data", DataOut, 32'h55AD1234);
    Enable = 0;
    @(posedge Clk); #1;
    chk("moc_fall", {30'b0, MOC, Busy}, 32'd0);

    // Enable dropped during ACCESS; inputs changed after acceptance are ignored
    ReadWrite = 1; Address = 9'h1FC; Mode = 2'd2; Enable = 1;
    @(posedge Clk); #1;
    Enable = 0; Address = 9'h010; Mode = 2'd0; ReadWrite = 0; DataIn = 32'h0;
    lat = 1;
    while (!MOC && lat < 50) begin
      @(posedge Clk); #1; lat++;
    end
    chk("drop_moc_latency", lat, WS + 2);
    chk("drop_latched_data", DataOut, 32'hCAFEF00D);
    @(posedge Clk); #1;
    chk("drop_one_cycle", {30'b0, MOC, Busy}, 32'd0);
    access(1'b1, 9'h010, 2'd2, 1'b0, 32'h0, dout, ae, lat);
    chk("no_stray_write", dout, 32'h55AD1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
